// File: rtl/rld.sv
// Run-length decoder. Fetches {count, value} byte pairs from the shared DPSRAM
// over port A, expands each pair into count copies of value, and writes the
// packed plaintext back through the same port. Read and write never share a
// cycle; a full output word is always written before the next read.
module rld #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       message_addr,
    output logic [31:0]       message_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StParse,
        StExpand,
        StWr,
        StFlush,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Next compressed word to fetch and next plaintext word to write.
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    // Compressed bytes (whole pairs only) not yet pulled into the input buffer.
    logic [31:0]       fetch_left_q, fetch_left_d;

    // Input word buffer; lane 0 is always the next byte to consume.
    logic [31:0]       in_buf_q, in_buf_d;
    logic [2:0]        in_cnt_q, in_cnt_d;

    // Pair being parsed and the run currently being expanded.
    logic              have_count_q, have_count_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        value_q, value_d;
    logic [7:0]        run_q, run_d;

    // Output word under assembly.
    logic [31:0]       out_buf_q, out_buf_d;
    logic [2:0]        out_lanes_q, out_lanes_d;

    logic [31:0]       msize_q, msize_d;
    logic              done_q, done_d;

    // Port A drive registers.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;

    // Scratch values for the next-state logic.
    logic [2:0]        lanes;
    state_e            resume_st;

    // Only the addressable, word-aligned address bits and whole pairs are used.
    logic unused_inputs;
    assign unused_inputs = ^{rle_addr[31:ADDR_W], rle_addr[1:0],
                             message_addr[31:ADDR_W], message_addr[1:0], rle_size[0]};

    assign port_A_clk     = clk;
    assign port_A_addr    = addr_q;
    assign port_A_we      = we_q;
    assign port_A_data_in = wdata_q;
    assign message_size   = msize_q;
    assign done           = done_q;

    // Next-state, datapath and port lookahead.
    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        fetch_left_d = fetch_left_q;
        in_buf_d     = in_buf_q;
        in_cnt_d     = in_cnt_q;
        have_count_d = have_count_q;
        count_d      = count_q;
        value_d      = value_q;
        run_d        = run_q;
        out_buf_d    = out_buf_q;
        out_lanes_d  = out_lanes_q;
        msize_d      = msize_q;
        lanes        = 3'd0;

        // Where to go once a run ends with no full word pending.
        if (in_cnt_q != 3'd0) begin
            resume_st = StParse;
        end else if (fetch_left_q != 32'd0) begin
            resume_st = StRdReq;
        end else begin
            resume_st = StFlush;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    rd_addr_d    = {rle_addr[ADDR_W-1:2], 2'b00};
                    wr_addr_d    = {message_addr[ADDR_W-1:2], 2'b00};
                    fetch_left_d = {rle_size[31:1], 1'b0};
                    in_buf_d     = 32'd0;
                    in_cnt_d     = 3'd0;
                    have_count_d = 1'b0;
                    count_d      = 8'd0;
                    value_d      = 8'd0;
                    run_d        = 8'd0;
                    out_buf_d    = 32'd0;
                    out_lanes_d  = 3'd0;
                    msize_d      = 32'd0;
                    state_d      = (rle_size < 32'd2) ? StDone : StRdReq;
                end
            end

            StRdReq: begin
                state_d = StRdWait;
            end

            StRdWait: begin
                lanes        = (fetch_left_q >= 32'd4) ? 3'd4 : fetch_left_q[2:0];
                in_buf_d     = port_A_data_out;
                in_cnt_d     = lanes;
                fetch_left_d = fetch_left_q - 32'(lanes);
                rd_addr_d    = rd_addr_q + ADDR_W'(4);
                state_d      = StParse;
            end

            StParse: begin
                if (in_cnt_q == 3'd0) begin
                    state_d = (fetch_left_q == 32'd0) ? StFlush : StRdReq;
                end else begin
                    in_buf_d = {8'h00, in_buf_q[31:8]};
                    in_cnt_d = in_cnt_q - 3'd1;
                    if (!have_count_q) begin
                        count_d      = in_buf_q[7:0];
                        have_count_d = 1'b1;
                    end else begin
                        value_d      = in_buf_q[7:0];
                        have_count_d = 1'b0;
                        // A zero-count pair produces nothing; keep parsing.
                        if (count_q != 8'd0) begin
                            run_d   = count_q;
                            state_d = StExpand;
                        end
                    end
                end
            end

            StExpand: begin
                out_buf_d[{out_lanes_q[1:0], 3'b000} +: 8] = value_q;
                out_lanes_d = out_lanes_q + 3'd1;
                run_d       = run_q - 8'd1;
                msize_d     = msize_q + 32'd1;
                if (out_lanes_q == 3'd3) begin
                    state_d = StWr;
                end else if (run_q == 8'd1) begin
                    state_d = resume_st;
                end
            end

            StWr: begin
                wr_addr_d   = wr_addr_q + ADDR_W'(4);
                out_buf_d   = 32'd0;
                out_lanes_d = 3'd0;
                state_d     = (run_q != 8'd0) ? StExpand : resume_st;
            end

            StFlush: begin
                out_buf_d   = 32'd0;
                out_lanes_d = 3'd0;
                state_d     = StDone;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Port A is registered: compute what the port must show in the next state.
    always_comb begin
        addr_d  = '0;
        we_d    = 1'b0;
        wdata_d = 32'd0;
        done_d  = (state_d == StDone);
        if (state_d == StRdReq) begin
            addr_d = rd_addr_d;
        end else if ((state_d == StWr) || ((state_d == StFlush) && (out_lanes_d != 3'd0))) begin
            addr_d  = wr_addr_d;
            we_d    = 1'b1;
            wdata_d = out_buf_d;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= StIdle;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            fetch_left_q <= 32'd0;
            in_buf_q     <= 32'd0;
            in_cnt_q     <= 3'd0;
            have_count_q <= 1'b0;
            count_q      <= 8'd0;
            value_q      <= 8'd0;
            run_q        <= 8'd0;
            out_buf_q    <= 32'd0;
            out_lanes_q  <= 3'd0;
            msize_q      <= 32'd0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            fetch_left_q <= fetch_left_d;
            in_buf_q     <= in_buf_d;
            in_cnt_q     <= in_cnt_d;
            have_count_q <= have_count_d;
            count_q      <= count_d;
            value_q      <= value_d;
            run_q        <= run_d;
            out_buf_q    <= out_buf_d;
            out_lanes_q  <= out_lanes_d;
            msize_q      <= msize_d;
            done_q       <= done_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_rld.sv
// Bench for rld: a synchronous-read memory model, a table of single-frame
// vectors, and hand-written long-run and reset-abort sequences.
module tb_rld;

    localparam int unsigned ADDR_W = 16;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       rle_addr = 32'd0;
    logic [31:0]       rle_size = 32'd0;
    logic [31:0]       message_addr = 32'd0;
    logic [31:0]       message_size;
    logic              done;
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;

    rld #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .start          (start),
        .rle_addr       (rle_addr),
        .rle_size       (rle_size),
        .message_addr   (message_addr),
        .message_size   (message_size),
        .done           (done),
        .port_A_clk     (port_A_clk),
        .port_A_addr    (port_A_addr),
        .port_A_we      (port_A_we),
        .port_A_data_in (port_A_data_in),
        .port_A_data_out(port_A_data_out)
    );

    always #5 clk = ~clk;

    // Memory model: address sampled at the edge, read data valid next cycle.
    logic [31:0] mem [0:16383];
    logic        bd_we = 1'b0;
    logic [13:0] bd_addr = 14'd0;
    logic [31:0] bd_data = 32'd0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (port_A_we) begin
            mem[port_A_addr[15:2]] <= port_A_data_in;
        end
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    // Reads show up as a nonzero address with we low; writes as we high.
    always @(posedge clk) begin
        if (port_A_we) wr_cnt <= wr_cnt + 1;
        if (!port_A_we && port_A_addr != '0) rd_cnt <= rd_cnt + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a[15:2];
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    function automatic logic [31:0] peek(input logic [31:0] a);
        return mem[a[15:2]];
    endfunction

    task automatic pulse_start(input logic [31:0] ra, input logic [31:0] rs,
                               input logic [31:0] ma);
        @(negedge clk);
        rle_addr     = ra;
        rle_size     = rs;
        message_addr = ma;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: done stayed 0, expected 1 within 3000 cycles", name);
        end
    endtask

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rs;
        logic [31:0] ma;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] sz;
        logic [31:0] o0;
        logic [31:0] o1;
        int          rd;
        int          wr;
    } vec_t;

    vec_t tbl [8];

    task automatic run_vec(input int idx, input vec_t v);
        int rd0;
        int wr0;
        logic [31:0] ra_w;
        logic [31:0] ma_w;
        string nm;
        nm   = $sformatf("v%0d", idx);
        ra_w = {v.ra[31:2], 2'b00};
        ma_w = {v.ma[31:2], 2'b00};
        poke(ra_w, v.w0);
        poke(ra_w + 32'd4, v.w1);
        poke(ma_w, SENT);
        poke(ma_w + 32'd4, SENT);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        pulse_start(v.ra, v.rs, v.ma);
        chk({nm, "_done_first"}, {31'd0, done}, {31'd0, v.rs < 32'd2});
        wait_done(nm);
        chk({nm, "_size"}, message_size, v.sz);
        chk({nm, "_word0"}, peek(ma_w), v.o0);
        chk({nm, "_word1"}, peek(ma_w + 32'd4), v.o1);
        chk({nm, "_reads"}, 32'(rd_cnt - rd0), 32'(v.rd));
        chk({nm, "_writes"}, 32'(wr_cnt - wr0), 32'(v.wr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int wr_snap;

        tbl[0] = '{32'h100, 32'd4, 32'h200, 32'h41034202, 32'h0,
                   32'd5, 32'h41414242, 32'h00000041, 1, 2};
        tbl[1] = '{32'h102, 32'd4, 32'h303, 32'h66015500, 32'h0,
                   32'd1, 32'h00000066, SENT, 1, 1};
        tbl[2] = '{32'h110, 32'd0, 32'h400, 32'h0, 32'h0, 32'd0, SENT, SENT, 0, 0};
        tbl[3] = '{32'h110, 32'd1, 32'h400, 32'h0, 32'h0, 32'd0, SENT, SENT, 0, 0};
        tbl[4] = '{32'h120, 32'd6, 32'h500, 32'h22021101, 32'h00093303,
                   32'd6, 32'h33222211, 32'h00003333, 2, 2};
        tbl[5] = '{32'h130, 32'd7, 32'h600, 32'h22021101, 32'h05093303,
                   32'd6, 32'h33222211, 32'h00003333, 2, 2};
        tbl[6] = '{32'h140, 32'd2, 32'h700, 32'h00007704, 32'h0,
                   32'd4, 32'h77777777, SENT, 1, 1};
        tbl[7] = '{32'h150, 32'd2, 32'h780, 32'h00005500, 32'h0,
                   32'd0, SENT, SENT, 1, 0};

        // Reset state.
        #12;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_size", message_size, 32'd0);
        chk("rst_we", {31'd0, port_A_we}, 32'd0);
        chk("rst_addr", 32'(port_A_addr), 32'd0);
        chk("rst_wdata", port_A_data_in, 32'd0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, tbl[i]);
        end

        // Maximum run: 255 copies of 0xAA.
        poke(32'h800, 32'h0000AAFF);
        poke(32'h1100, SENT);
        begin
            int rd0;
            int wr0;
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            pulse_start(32'h800, 32'd2, 32'h1000);
            wait_done("run255");
            chk("run255_size", message_size, 32'd255);
            chk("run255_reads", 32'(rd_cnt - rd0), 32'd1);
            chk("run255_writes", 32'(wr_cnt - wr0), 32'd64);
        end
        bad = 0;
        for (int w = 0; w < 63; w++) begin
            if (peek(32'h1000 + 32'(4 * w)) !== 32'hAAAAAAAA) bad++;
        end
        chk("run255_full_words_bad", 32'(bad), 32'd0);
        chk("run255_last_word", peek(32'h10FC), 32'h00AAAAAA);
        chk("run255_past_end", peek(32'h1100), SENT);

        // Abort mid-expand with reset.
        pulse_start(32'h800, 32'd2, 32'h2000);
        repeat (30) @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_size", message_size, 32'd0);
        chk("abort_we", {31'd0, port_A_we}, 32'd0);
        chk("abort_addr", 32'(port_A_addr), 32'd0);
        chk("abort_wdata", port_A_data_in, 32'd0);
        wr_snap = wr_cnt;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_writes", 32'(wr_cnt - wr_snap), 32'd0);

        // Fresh frame after abort; a start while busy must be ignored.
        poke(32'h900, 32'h41034202);
        poke(32'hA00, SENT);
        poke(32'hA04, SENT);
        pulse_start(32'h900, 32'd4, 32'hA00);
        repeat (2) @(posedge clk);
        pulse_start(32'h110, 32'd0, 32'hB00);
        wait_done("after_abort");
        chk("after_abort_size", message_size, 32'd5);
        chk("after_abort_word0", peek(32'hA00), 32'h41414242);
        chk("after_abort_word1", peek(32'hA04), 32'h00000041);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
